// File: rtl/rename_unit.sv
// -----------------------------------------------------------------------------
// rename_unit
//   N-wide register renamer between decode and dispatch. Architectural
//   rs1/rs2/rd are mapped to physical tags through a speculative RAT; new
//   destinations are popped from a circular free list. Younger lanes in a
//   group see the destinations of older lanes (intra-group bypass). Retire
//   commits mappings to an architectural RAT and pushes the old tag back on
//   the free list. Flush restores the speculative RAT from the architectural
//   one and rewinds the free-list head to the committed position.
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_wr/in_rs1/in_rs2/in_rd  decode group, lane 0 oldest
//   in_ready                         group accepted when in_ready & |in_valid
//   out_valid/out_prs1/out_prs2/out_prd/out_old_prd  registered renamed group
//   out_ready                        dispatch consumes out_* this cycle
//   ret_valid/ret_rd/ret_prd/ret_old_prd  in-order retire ports, port 0 oldest
//   flush                            drop all un-retired speculative state
//   free_count                       free-list occupancy (tail - head)
// -----------------------------------------------------------------------------
module rename_unit #(
    parameter  int NUM_ARCH  = 32,
    parameter  int NUM_PHYS  = 64,
    parameter  int WIDTH     = 2,
    parameter  int RET_WIDTH = 2,
    localparam int AW        = $clog2(NUM_ARCH),
    localparam int PW        = $clog2(NUM_PHYS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        in_valid,
    input  logic [WIDTH-1:0]        in_wr,
    input  logic [WIDTH*AW-1:0]     in_rs1,
    input  logic [WIDTH*AW-1:0]     in_rs2,
    input  logic [WIDTH*AW-1:0]     in_rd,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_valid,
    output logic [WIDTH*PW-1:0]     out_prs1,
    output logic [WIDTH*PW-1:0]     out_prs2,
    output logic [WIDTH*PW-1:0]     out_prd,
    output logic [WIDTH*PW-1:0]     out_old_prd,
    input  logic                    out_ready,
    input  logic [RET_WIDTH-1:0]    ret_valid,
    input  logic [RET_WIDTH*AW-1:0] ret_rd,
    input  logic [RET_WIDTH*PW-1:0] ret_prd,
    input  logic [RET_WIDTH*PW-1:0] ret_old_prd,
    input  logic                    flush,
    output logic [PW:0]             free_count
);

    localparam int FREE_INIT = NUM_PHYS - NUM_ARCH;

    logic [PW-1:0] spec_rat  [NUM_ARCH];
    logic [PW-1:0] arch_rat  [NUM_ARCH];
    logic [PW-1:0] free_list [NUM_PHYS];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0] head, commit_head, tail;

    // Lane / port unpacking.
    logic [AW-1:0] rs1_a [WIDTH];
    logic [AW-1:0] rs2_a [WIDTH];
    logic [AW-1:0] rd_a  [WIDTH];
    logic [AW-1:0] ret_rd_a      [RET_WIDTH];
    logic [PW-1:0] ret_prd_a     [RET_WIDTH];
    logic [PW-1:0] ret_old_prd_a [RET_WIDTH];

    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        assign rs1_a[k] = in_rs1[k*AW +: AW];
        assign rs2_a[k] = in_rs2[k*AW +: AW];
        assign rd_a[k]  = in_rd[k*AW +: AW];
    end

    for (genvar p = 0; p < RET_WIDTH; p++) begin : g_ret
        assign ret_rd_a[p]      = ret_rd[p*AW +: AW];
        assign ret_prd_a[p]     = ret_prd[p*PW +: PW];
        assign ret_old_prd_a[p] = ret_old_prd[p*PW +: PW];
    end

    assign free_count = tail - head;
    assign in_ready   = !flush && (free_count >= (PW+1)'(WIDTH))
                        && ((out_valid == '0) || out_ready);

    logic accept;
    assign accept = in_ready && (in_valid != '0);

    // ---------------------------------------------------------------- rename
    logic [WIDTH-1:0] alloc;
    logic [PW:0]      pop_ptr  [WIDTH];
    logic [PW:0]      pop_cnt;
    logic [PW-1:0]    ren_prs1 [WIDTH];
    logic [PW-1:0]    ren_prs2 [WIDTH];
    logic [PW-1:0]    ren_prd  [WIDTH];
    logic [PW-1:0]    ren_old  [WIDTH];

    // NOTE: every variable driven here gets a value on every path before it
    // is read, so the block stays purely combinational (no inferred latches).
    always_comb begin
        pop_cnt = '0;
        for (int k = 0; k < WIDTH; k++) begin
            alloc[k]    = in_valid[k] & in_wr[k] & (rd_a[k] != '0);
            pop_ptr[k]  = head + pop_cnt;
            ren_prs1[k] = (rs1_a[k] == '0) ? '0 : spec_rat[rs1_a[k]];
            ren_prs2[k] = (rs2_a[k] == '0) ? '0 : spec_rat[rs2_a[k]];
            ren_old[k]  = alloc[k] ? spec_rat[rd_a[k]] : '0;
            // Older lanes are scanned oldest-first so the youngest match wins.
            // An allocating lane never has rd == 0, so source 0 never matches.
            for (int j = 0; j < k; j++) begin
                if (alloc[j] && (rd_a[j] == rs1_a[k])) ren_prs1[k] = ren_prd[j];
                if (alloc[j] && (rd_a[j] == rs2_a[k])) ren_prs2[k] = ren_prd[j];
                if (alloc[k] && alloc[j] && (rd_a[j] == rd_a[k])) ren_old[k] = ren_prd[j];
            end
            // Packed pops: the n-th allocating lane takes entry head+n.
            ren_prd[k]  = alloc[k] ? free_list[pop_ptr[k][PW-1:0]] : '0;
            pop_cnt     = pop_cnt + (PW+1)'(alloc[k]);
        end
    end

    // ---------------------------------------------------------------- retire
    logic [PW-1:0] arch_next [NUM_ARCH];
    logic [PW:0]   ret_ptr   [RET_WIDTH];
    logic [PW:0]   ret_cnt;

    // Ports applied in order so the youngest duplicate rd lands last.
    always_comb begin
        arch_next = arch_rat;
        ret_cnt   = '0;
        for (int p = 0; p < RET_WIDTH; p++) begin
            ret_ptr[p] = tail + ret_cnt;
            if (ret_valid[p]) begin
                arch_next[ret_rd_a[p]] = ret_prd_a[p];
                ret_cnt                = ret_cnt + (PW+1)'(1);
            end
        end
    end

    // ----------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the free list is architecturally visible state (its reset
            // contents are the initial free tags), so this memory is reset.
            for (int i = 0; i < NUM_ARCH; i++) begin
                spec_rat[i] <= PW'(i);
                arch_rat[i] <= PW'(i);
            end
            for (int i = 0; i < NUM_PHYS; i++) begin
                free_list[i] <= (i < FREE_INIT) ? PW'(NUM_ARCH + i) : '0;
            end
            head        <= '0;
            commit_head <= '0;
            tail        <= (PW+1)'(FREE_INIT);
            out_valid   <= '0;
            out_prs1    <= '0;
            out_prs2    <= '0;
            out_prd     <= '0;
            out_old_prd <= '0;
        end else begin
            arch_rat    <= arch_next;
            tail        <= tail + ret_cnt;
            commit_head <= commit_head + ret_cnt;
            for (int p = 0; p < RET_WIDTH; p++) begin
                if (ret_valid[p]) free_list[ret_ptr[p][PW-1:0]] <= ret_old_prd_a[p];
            end

            if (flush) begin
                // Retires of this same cycle are already folded into arch_next.
                spec_rat  <= arch_next;
                head      <= commit_head + ret_cnt;
                out_valid <= '0;
            end else if (accept) begin
                for (int k = 0; k < WIDTH; k++) begin
                    if (alloc[k]) spec_rat[rd_a[k]] <= ren_prd[k];
                end
                head      <= head + pop_cnt;
                out_valid <= in_valid;
                for (int k = 0; k < WIDTH; k++) begin
                    out_prs1[k*PW +: PW]    <= ren_prs1[k];
                    out_prs2[k*PW +: PW]    <= ren_prs2[k];
                    out_prd[k*PW +: PW]     <= ren_prd[k];
                    out_old_prd[k*PW +: PW] <= ren_old[k];
                end
            end else if (out_ready) begin
                out_valid <= '0;
            end
        end
    end

    a_free_bound: assert property (@(posedge clk) disable iff (rst)
        free_count <= (PW+1)'(FREE_INIT));

endmodule
